// File: rtl/ch3_wave_seq.sv
`default_nettype none
// ============================================================================
// Module   : ch3_wave_seq
// Purpose  : Wave channel sequencer: period/position/length counters, wave
//            RAM fetch and CPU arbitration, volume-scaled 4-bit sample.
// Revision : 1.0 - initial release
// ============================================================================
module ch3_wave_seq (
    input  logic        cery_2mhz,
    input  logic        napu_reset,
    input  logic        trig,
    input  logic        dac_en,
    input  logic        len_en,
    input  logic        len_wr,
    input  logic        len_tick,
    input  logic [10:0] freq,
    input  logic [7:0]  len_data,
    input  logic [1:0]  vol_code,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [3:0]  wram_addr,
    output logic        wram_rd,
    output logic        wram_wr,
    output logic [7:0]  wram_wdata,
    input  logic [7:0]  wram_rdata,
    output logic        ch3_active,
    output logic [3:0]  sample_out
);

    localparam logic [1:0]  S_OFF        = 2'd0;
    localparam logic [1:0]  S_RUN        = 2'd1;
    localparam logic [1:0]  S_FETCH      = 2'd2;
    localparam logic [10:0] C_PERIOD_TOP = 11'h7FF;
    localparam logic [8:0]  C_LEN_FULL   = 9'd256;

    logic [1:0]  r_state,  w_state_n;
    logic [10:0] r_period, w_period_n;
    logic [4:0]  r_pos,    w_pos_n;
    logic [3:0]  r_buf,    w_buf_n;
    logic [8:0]  r_len,    w_len_n;
    logic        r_fp, r_fp_lo, r_fp_cw;
    logic [7:0]  r_cw_byte;
    logic        r_rdp, r_rdp_ff;
    logic        w_off, w_fetch, w_ovf, w_len_kill;
    logic [7:0]  w_fetch_byte;
    logic [3:0]  w_sample_n;

    assign w_off        = (r_state == S_OFF);
    assign w_fetch      = (r_state == S_FETCH);
    assign w_ovf        = !w_off && (r_period == C_PERIOD_TOP);
    // A CPU write during FETCH replaces the byte the channel would have read
    assign w_fetch_byte = r_fp_cw ? r_cw_byte : wram_rdata;

    always_comb begin
        w_len_n    = r_len;
        w_len_kill = 1'b0;
        if (trig) begin
            if (r_len == 9'd0) w_len_n = C_LEN_FULL;
        end else if (len_wr) begin
            w_len_n = C_LEN_FULL - {1'b0, len_data};
        end else if (len_tick && len_en && (r_len != 9'd0)) begin
            w_len_n    = r_len - 9'd1;
            w_len_kill = (r_len == 9'd1);
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_period_n = r_period;
        w_pos_n    = r_pos;
        if (!dac_en) begin
            w_state_n = S_OFF;
        end else if (trig) begin
            w_state_n  = S_RUN;
            w_period_n = freq;
            w_pos_n    = 5'd0;
        end else if (w_len_kill) begin
            w_state_n = S_OFF;
        end else if (!w_off) begin
            if (w_ovf) begin
                w_state_n  = S_FETCH;
                w_period_n = freq;
                w_pos_n    = r_pos + 5'd1;
            end else begin
                w_state_n  = S_RUN;
                w_period_n = r_period + 11'd1;
            end
        end
    end

    always_comb begin
        w_buf_n = r_buf;
        if (r_fp) w_buf_n = r_fp_lo ? w_fetch_byte[3:0] : w_fetch_byte[7:4];
        w_sample_n = 4'd0;
        if (w_state_n != S_OFF) begin
            case (vol_code)
                2'd1:    w_sample_n = w_buf_n;
                2'd2:    w_sample_n = w_buf_n >> 1;
                2'd3:    w_sample_n = w_buf_n >> 2;
                default: w_sample_n = 4'd0;
            endcase
        end
    end

    // RAM strobes follow the CPU strobes combinationally; held quiet in reset
    always_comb begin
        wram_rd    = 1'b0;
        wram_wr    = 1'b0;
        wram_addr  = 4'd0;
        wram_wdata = 8'd0;
        if (napu_reset) begin
            if (w_off) begin
                wram_addr  = cpu_addr;
                wram_wr    = cpu_wr;
                wram_rd    = cpu_rd && !cpu_wr;
                wram_wdata = cpu_wr ? cpu_wdata : 8'd0;
            end else if (w_fetch) begin
                wram_addr  = r_pos[4:1];
                wram_wr    = cpu_wr;
                wram_rd    = !cpu_wr;
                wram_wdata = cpu_wr ? cpu_wdata : 8'd0;
            end
        end
    end

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            r_state    <= S_OFF;
            r_period   <= 11'd0;
            r_pos      <= 5'd0;
            r_buf      <= 4'd0;
            r_len      <= 9'd0;
            r_fp       <= 1'b0;
            r_fp_lo    <= 1'b0;
            r_fp_cw    <= 1'b0;
            r_cw_byte  <= 8'd0;
            r_rdp      <= 1'b0;
            r_rdp_ff   <= 1'b0;
            cpu_rdata  <= 8'hFF;
            ch3_active <= 1'b0;
            sample_out <= 4'd0;
        end else begin
            r_state    <= w_state_n;
            r_period   <= w_period_n;
            r_pos      <= w_pos_n;
            r_buf      <= w_buf_n;
            r_len      <= w_len_n;
            r_fp       <= w_fetch;
            r_fp_lo    <= r_pos[0];
            r_fp_cw    <= cpu_wr;
            r_cw_byte  <= cpu_wdata;
            r_rdp      <= cpu_rd && !(w_off && cpu_wr);
            r_rdp_ff   <= (r_state == S_RUN);
            if (r_rdp) cpu_rdata <= r_rdp_ff ? 8'hFF : (r_fp ? w_fetch_byte : wram_rdata);
            ch3_active <= (w_state_n != S_OFF);
            sample_out <= w_sample_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ch3_wave_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ch3_wave_seq
// Purpose  : Directed bench for ch3_wave_seq with a cycle-level channel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ch3_wave_seq;

    logic        clk = 1'b0;
    logic        napu_reset = 1'b0;
    logic        trig = 1'b0, dac_en = 1'b0, len_en = 1'b0, len_wr = 1'b0, len_tick = 1'b0;
    logic [10:0] freq = 11'd0;
    logic [7:0]  len_data = 8'd0;
    logic [1:0]  vol_code = 2'd0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [3:0]  cpu_addr = 4'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic [7:0]  cpu_rdata, wram_wdata, wram_rdata;
    logic [3:0]  wram_addr, sample_out;
    logic        wram_rd, wram_wr, ch3_active;

    ch3_wave_seq dut (
        .cery_2mhz(clk), .napu_reset(napu_reset), .trig(trig), .dac_en(dac_en),
        .len_en(len_en), .len_wr(len_wr), .len_tick(len_tick), .freq(freq),
        .len_data(len_data), .vol_code(vol_code), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .wram_addr(wram_addr), .wram_rd(wram_rd), .wram_wr(wram_wr),
        .wram_wdata(wram_wdata), .wram_rdata(wram_rdata),
        .ch3_active(ch3_active), .sample_out(sample_out)
    );

    always #5 clk = ~clk;

    // Wave RAM seen by the DUT
    logic [7:0] mem [16];
    logic [7:0] ram_q = 8'd0;
    assign wram_rdata = ram_q;
    always_ff @(posedge clk) begin
        if (wram_wr) mem[wram_addr] <= wram_wdata;
        if (wram_rd) ram_q <= mem[wram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Channel model: countdown to the next fetch, explicit shadow RAM
    logic [7:0] shadow [16];
    bit         m_active, m_fetch, p_fetch, p_lo, p_rd, kill;
    int         m_pos, m_cnt, m_len, m_sample;
    logic [3:0] m_buf;
    logic [7:0] m_rdata, p_byte, p_rdval;

    initial forever begin
        @(posedge clk or negedge napu_reset);
        if (!napu_reset) begin
            m_active = 0; m_fetch = 0; m_pos = 0; m_cnt = 0; m_len = 0;
            m_buf = 4'd0; m_rdata = 8'hFF; p_fetch = 0; p_rd = 0; m_sample = 0;
        end else begin
            if (p_fetch) m_buf = p_lo ? p_byte[3:0] : p_byte[7:4];
            if (p_rd) m_rdata = p_rdval;
            p_fetch = 0;
            p_rd = 0;
            if (!m_active) begin
                if (cpu_wr) shadow[cpu_addr] = cpu_wdata;
                else if (cpu_rd) begin p_rd = 1; p_rdval = shadow[cpu_addr]; end
            end else if (m_fetch) begin
                p_fetch = 1;
                p_lo = (m_pos % 2) == 1;
                if (cpu_wr) shadow[m_pos / 2] = cpu_wdata;
                p_byte = shadow[m_pos / 2];
                if (cpu_rd) begin p_rd = 1; p_rdval = p_byte; end
            end else if (cpu_rd) begin
                p_rd = 1; p_rdval = 8'hFF;
            end
            kill = 0;
            if (trig) begin
                if (m_len == 0) m_len = 256;
            end else if (len_wr) begin
                m_len = 256 - int'(len_data);
            end else if (len_tick && len_en && m_len > 0) begin
                m_len--;
                kill = (m_len == 0);
            end
            m_fetch = 0;
            if (!dac_en) m_active = 0;
            else if (trig) begin m_active = 1; m_pos = 0; m_cnt = 2048 - int'(freq); end
            else if (kill) m_active = 0;
            else if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pos = (m_pos + 1) % 32;
                    m_fetch = 1;
                    m_cnt = 2048 - int'(freq);
                end
            end
            m_sample = (m_active && vol_code != 2'd0) ? (int'(m_buf) >> (int'(vol_code) - 1)) : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (napu_reset) begin
            bit exp_rd, exp_wr;
            int exp_addr;
            exp_rd = 0; exp_wr = 0; exp_addr = 0;
            if (!m_active) begin
                exp_wr = cpu_wr; exp_rd = cpu_rd && !cpu_wr; exp_addr = int'(cpu_addr);
            end else if (m_fetch) begin
                exp_wr = cpu_wr; exp_rd = !cpu_wr; exp_addr = m_pos / 2;
            end
            check("active", int'(ch3_active), int'(m_active));
            check("sample", int'(sample_out), m_sample);
            check("cpu_rdata", int'(cpu_rdata), int'(m_rdata));
            check("wram_rd", int'(wram_rd), int'(exp_rd));
            check("wram_wr", int'(wram_wr), int'(exp_wr));
            if (exp_rd || exp_wr) check("wram_addr", int'(wram_addr), exp_addr);
            if (exp_wr) check("wram_wdata", int'(wram_wdata), int'(cpu_wdata));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'(i * 17 + 3);
            shadow[i] = 8'(i * 17 + 3);
        end
        mem[0] = 8'hA5; shadow[0] = 8'hA5;
        mem[3] = 8'h3C; shadow[3] = 8'h3C;

        // Reset: strobes gated even with CPU activity present
        cpu_rd = 1'b1; cpu_addr = 4'h9;
        run(3);
        @(negedge clk);
        check("rst_active", int'(ch3_active), 0);
        check("rst_sample", int'(sample_out), 0);
        check("rst_rdata", int'(cpu_rdata), 8'hFF);
        check("rst_wram_rd", int'(wram_rd), 0);
        check("rst_wram_addr", int'(wram_addr), 0);
        cpu_rd = 1'b0; cpu_addr = 4'h0;
        step();
        napu_reset = 1'b1;
        step();

        // OFF: CPU owns the RAM
        cpu_wr = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'h5A;
        @(negedge clk);
        check("off_wr_strobe", int'(wram_wr), 1);
        check("off_wr_addr", int'(wram_addr), 7);
        step();
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        step();
        @(negedge clk);
        check("off_rd_data", int'(cpu_rdata), 8'h5A);
        run(3);
        check("rdata_hold", int'(cpu_rdata), 8'h5A);

        // Fastest useful period: fetch every 2 cycles, address walk with wrap
        vol_code = 2'd1; freq = 11'h7FE; dac_en = 1'b1;
        pulse_trig();
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            check("fast_fetch_rd", int'(wram_rd), (c >= 2 && c % 2 == 0) ? 1 : 0);
            if (c >= 2 && c % 2 == 0) check("fast_fetch_addr", int'(wram_addr), (((c - 2) / 2 + 1) % 32) / 2);
            if (c == 4) check("fast_sample_pos1", int'(sample_out), 5);
            if (c == 6) check("fast_sample_pos2", int'(sample_out), 1);
            step();
        end

        // Volume shifts on the odd nibble of byte 0 (restart while running)
        freq = 11'h700;
        pulse_trig();
        run(258);
        @(negedge clk);
        check("vol01", int'(sample_out), 5);
        vol_code = 2'd2; step(); @(negedge clk);
        check("vol10", int'(sample_out), 2);
        vol_code = 2'd3; step(); @(negedge clk);
        check("vol11", int'(sample_out), 1);
        vol_code = 2'd0; step(); @(negedge clk);
        check("vol00", int'(sample_out), 0);
        vol_code = 2'd1;

        // CPU access while the channel runs
        pulse_trig();
        run(100);
        cpu_rd = 1'b1; step(); cpu_rd = 1'b0; step();
        @(negedge clk);
        check("run_rd_ff", int'(cpu_rdata), 8'hFF);
        run(1536 - 102);
        cpu_rd = 1'b1;
        @(negedge clk);
        check("fetch6_rd", int'(wram_rd), 1);
        check("fetch6_addr", int'(wram_addr), 3);
        step(); cpu_rd = 1'b0; step();
        @(negedge clk);
        check("fetch_rd_data", int'(cpu_rdata), 8'h3C);
        check("fetch6_sample", int'(sample_out), 3);
        run(1792 - 1538);
        cpu_wr = 1'b1; cpu_wdata = 8'h99;
        @(negedge clk);
        check("fetch_wr_strobe", int'(wram_wr), 1);
        check("fetch_wr_no_rd", int'(wram_rd), 0);
        check("fetch_wr_addr", int'(wram_addr), 3);
        step(); cpu_wr = 1'b0; step();
        @(negedge clk);
        check("byte3_written", int'(mem[3]), 8'h99);
        check("fetch_wr_sample", int'(sample_out), 9);

        // DAC off stops the channel on the next edge
        dac_en = 1'b0; step(); @(negedge clk);
        check("dac_off_active", int'(ch3_active), 0);
        check("dac_off_sample", int'(sample_out), 0);
        cpu_rd = 1'b1; cpu_addr = 4'd3; step(); cpu_rd = 1'b0; step();
        @(negedge clk);
        check("off_rd_byte3", int'(cpu_rdata), 8'h99);

        // Length counter
        dac_en = 1'b1; len_data = 8'hFE; len_wr = 1'b1; step(); len_wr = 1'b0;
        len_en = 1'b1;
        pulse_trig();
        len_tick = 1'b1; step(); len_tick = 1'b0; @(negedge clk);
        check("len_tick1_active", int'(ch3_active), 1);
        len_tick = 1'b1; step(); len_tick = 1'b0; @(negedge clk);
        check("len_tick2_off", int'(ch3_active), 0);
        len_tick = 1'b1; step(); len_tick = 1'b0;
        trig = 1'b1; len_tick = 1'b1; step(); trig = 1'b0;
        run(255);
        @(negedge clk);
        check("len256_alive", int'(ch3_active), 1);
        step(); len_tick = 1'b0;
        @(negedge clk);
        check("len256_off", int'(ch3_active), 0);
        len_en = 1'b0;

        // Reset in the middle of a fetch
        freq = 11'h7FE;
        pulse_trig();
        run(2);
        #2 napu_reset = 1'b0;
        #1;
        check("rst_fetch_active", int'(ch3_active), 0);
        check("rst_fetch_rd", int'(wram_rd), 0);
        check("rst_fetch_addr", int'(wram_addr), 0);
        check("rst_fetch_rdata", int'(cpu_rdata), 8'hFF);
        check("rst_fetch_sample", int'(sample_out), 0);
        @(posedge clk);
        #3 napu_reset = 1'b1;
        dac_en = 1'b0;
        step();
        pulse_trig();
        @(negedge clk);
        check("trig_dac_off", int'(ch3_active), 0);
        dac_en = 1'b1;
        pulse_trig();
        run(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ch3_wave_seq.md
CH3_WAVE_SEQ -- requirements
Module: ch3_wave_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: cery_2mhz (input, 1, 2 MHz APU clock; all state on its rising edge) and napu_reset (input, 1, async active-low reset).
REQ-002 SHALL have these control inputs, all 1 bit:
- trig: one-cycle NR34 bit-7 write pulse.
- dac_en: NR30 bit 7.
- len_en: NR34 bit 6.
- len_wr: one-cycle NR31 write pulse.
- len_tick: one-cycle 256 Hz frame-sequencer pulse.
REQ-003 SHALL have these data inputs: freq (11, NR33/NR34 period), len_data (8, NR31 value), vol_code (2, NR32 bits 6:5).
REQ-004 SHALL have these CPU-side ports:
- Inputs: cpu_rd (1) and cpu_wr (1), one-cycle FF30-FF3F strobes; cpu_addr (4); cpu_wdata (8).
- Output: cpu_rdata (8).
REQ-005 SHALL have these wave RAM ports: outputs wram_addr (4), wram_rd (1), wram_wr (1), wram_wdata (8); input wram_rdata (8), valid one cycle after wram_rd.
REQ-006 SHALL have these status outputs: ch3_active (1, channel on, NR52 bit 2) and sample_out (4, volume-scaled sample).

Function
REQ-007 SHALL implement FSM states OFF, RUN and FETCH.
- OFF->RUN: trig with dac_en=1.
- RUN->FETCH: period counter overflow.
- FETCH->RUN: after exactly one cycle.
- Any state->OFF: dac_en=0, or length counter reaching 0.
REQ-008 SHALL assert ch3_active=1 in RUN and FETCH and 0 in OFF.
REQ-009 Period counter: SHALL be 11 bits and increment each cycle in RUN/FETCH; on 0x7FF it reloads freq and flags overflow, giving period 2048-freq cycles.
REQ-010 Position counter: SHALL be 5 bits and increment on overflow, wrapping 31->0.
REQ-011 FETCH cycle:
- SHALL drive wram_rd=1 and wram_addr=new position[4:1].
- Next cycle: SHALL latch wram_rdata[7:4] into the sample buffer for even positions, wram_rdata[3:0] for odd.
REQ-012 sample_out SHALL be buffer>>shift, where vol_code 00 gives 0, 01 gives shift 0, 10 gives shift 1 and 11 gives shift 2; sample_out SHALL be 0 in OFF.
REQ-013 trig with dac_en=1:
- SHALL set position=0 and period counter=freq.
- SHALL retain the sample buffer (first fetch occurs at position 1).
- SHALL load the length counter with 256 if it is 0.
- Applies in any state, including restart while running.
REQ-014 trig with dac_en=0 SHALL leave the FSM in OFF; the length reload still applies.
REQ-015 Length counter: SHALL be 9 bits.
- len_wr loads 256-len_data.
- len_tick with len_en=1 and count>0 decrements it.
- The decrement to 0 forces OFF on the same edge.
REQ-016 Length decrement SHALL operate in all states.
REQ-017 CPU access in OFF:
- wram_addr=cpu_addr.
- cpu_rd: wram_rd=1, and cpu_rdata=wram_rdata registered one cycle later.
- cpu_wr: wram_wr=1 with wram_wdata=cpu_wdata.
REQ-018 CPU access in RUN/FETCH:
- The channel owns the RAM and cpu_addr is ignored.
- cpu_rd coincident with FETCH: cpu_rdata = the byte fetched by the channel, one cycle later.
- cpu_rd otherwise: cpu_rdata=0xFF one cycle later.
- cpu_wr coincident with FETCH: writes cpu_wdata to the channel's current byte address (wram_wr=1, wram_rd=0); the sample buffer then latches cpu_wdata.
- cpu_wr otherwise: dropped.
REQ-019 wram_rd and wram_wr SHALL never be asserted in the same cycle.
REQ-020 Simultaneous-event priority: reset > dac_en=0 > trig > len_wr > len_tick > overflow.
- trig on a len_tick cycle: no decrement that cycle.
- trig on an overflow cycle: trig wins, no FETCH.
REQ-021 cpu_rdata SHALL hold its last value between reads.

Reset
REQ-022 napu_reset=0 SHALL asynchronously force:
- FSM=OFF.
- Period counter, position, sample buffer and length counter to 0.
- cpu_rdata=0xFF.
- wram_rd, wram_wr, wram_addr, wram_wdata, ch3_active and sample_out to 0.
REQ-023 Reset mid-FETCH SHALL abort the fetch with no buffer update after release.
REQ-024 After release, the block SHALL stay in OFF until a trig with dac_en=1.

Verification
REQ-025 freq=0x7FE, dac_en=1, trig -> FETCH every 2 cycles; wram_addr sequence 0,1,1,2,2,...,15,15,0; position wraps 31->0.
REQ-026 Wave RAM byte0=0xA5, vol_code=01 then 10 then 11 -> at position 1 (odd nibble) sample_out=5, then 2, then 1; vol_code=00 -> 0.
REQ-027 len_data=0xFE, len_wr, len_en=1, trig, two len_tick pulses -> ch3_active falls on the second tick edge; a third tick leaves the count at 0.
REQ-028 Active with freq=0x700: cpu_rd outside FETCH -> cpu_rdata=0xFF; cpu_rd during FETCH of byte 3 (=0x3C) -> cpu_rdata=0x3C; cpu_wr 0x99 during FETCH -> byte 3 becomes 0x99.
REQ-029 OFF: cpu_wr addr 7 data 0x5A, then cpu_rd addr 7 -> cpu_rdata=0x5A one cycle later; dac_en=0 during RUN -> OFF next edge and sample_out=0.
REQ-030 napu_reset pulsed during FETCH -> all outputs reset immediately; trig with dac_en=0 after release -> ch3_active stays 0.
